// File: rtl/audio_serializer_pkg.sv
// Shared constants and state encoding for the I2S audio serializer.
package audio_serializer_pkg;

    localparam int AUDIO_SAMPLE_BIT_WIDTH   = 16;
    localparam int AUDIO_SLOT_BITS          = 32;
    localparam int AUDIO_SLOT_CNT_BIT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } audio_state_t;

endpackage

// File: rtl/edge_sync_detect.sv
// Two-flop synchronizer for a slow external level, plus single-cycle rise and
// fall strobes in the system clock domain. Also usable for the keyboard clock.
module edge_sync_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain followed by a history flop for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~prev_q;
    assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/audio_serializer.sv
// Serializes 16-bit stereo PCM pairs into an I2S stream. The divided bit clock
// is sampled as data; every output change happens on its synchronized falling
// edge. A one-deep holding register decouples the producer from frame timing.
module audio_serializer
    import audio_serializer_pkg::*;
#(
    parameter int SAMPLE_BIT_WIDTH   = AUDIO_SAMPLE_BIT_WIDTH,
    parameter int SLOT_BITS          = AUDIO_SLOT_BITS,
    parameter int SLOT_CNT_BIT_WIDTH = AUDIO_SLOT_CNT_BIT_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clk_audio_bit,
    input  logic [SAMPLE_BIT_WIDTH-1:0] sample_l,
    input  logic [SAMPLE_BIT_WIDTH-1:0] sample_r,
    input  logic                        sample_valid,
    output logic                        sample_ready,
    output logic                        audio_bclk,
    output logic                        audio_lrck,
    output logic                        audio_sdin,
    output logic                        underrun
);

    // A slot must hold the one-bit I2S delay plus every sample bit, and the
    // counter must be able to reach the last slot index.
    generate
        if (SLOT_BITS < SAMPLE_BIT_WIDTH + 1) begin : g_bad_slot_bits
            $error("SLOT_BITS must be at least SAMPLE_BIT_WIDTH+1");
        end
        if ((1 << SLOT_CNT_BIT_WIDTH) < SLOT_BITS) begin : g_bad_cnt_width
            $error("SLOT_CNT_BIT_WIDTH too narrow for SLOT_BITS");
        end
    endgenerate

    localparam logic [SLOT_CNT_BIT_WIDTH-1:0] CNT_LAST  = SLOT_CNT_BIT_WIDTH'(SLOT_BITS - 1);
    localparam logic [SLOT_CNT_BIT_WIDTH-1:0] DATA_LAST = SLOT_CNT_BIT_WIDTH'(SAMPLE_BIT_WIDTH);

    logic bclk_fall;
    logic bclk_rise_unused;

    audio_state_t                  state_q, state_d;
    logic [SLOT_CNT_BIT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic                          lrck_q, lrck_d;
    logic                          sdin_q, sdin_d;
    logic                          underrun_q, underrun_d;
    logic [SAMPLE_BIT_WIDTH-1:0]   shift_l_q, shift_l_d;
    logic [SAMPLE_BIT_WIDTH-1:0]   shift_r_q, shift_r_d;
    logic                          hold_full_q, hold_full_d;
    logic [SAMPLE_BIT_WIDTH-1:0]   hold_l_q, hold_l_d;
    logic [SAMPLE_BIT_WIDTH-1:0]   hold_r_q, hold_r_d;
    logic                          accept;
    logic                          frame_load;

    // The rise strobe is not needed here; only falling edges advance the stream.
    edge_sync_detect u_bclk_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (clk_audio_bit),
        .sync_out (audio_bclk),
        .rise     (bclk_rise_unused),
        .fall     (bclk_fall)
    );

    assign cnt_inc = cnt_q + 1'b1;
    assign accept  = sample_valid && !hold_full_q;

    // Next-state logic: handshake capture, slot sequencing and frame loading.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lrck_d      = lrck_q;
        sdin_d      = sdin_q;
        underrun_d  = 1'b0;
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        frame_load  = 1'b0;

        if (accept) begin
            hold_full_d = 1'b1;
            hold_l_d    = sample_l;
            hold_r_d    = sample_r;
        end

        if (bclk_fall) begin
            unique case (state_q)
                IDLE: begin
                    state_d    = LEFT;
                    cnt_d      = '0;
                    lrck_d     = 1'b0;
                    sdin_d     = 1'b0;
                    frame_load = 1'b1;
                end
                LEFT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = RIGHT;
                        cnt_d   = '0;
                        lrck_d  = 1'b1;
                        sdin_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc <= DATA_LAST) begin
                            sdin_d    = shift_l_q[SAMPLE_BIT_WIDTH-1];
                            shift_l_d = {shift_l_q[SAMPLE_BIT_WIDTH-2:0], 1'b0};
                        end else begin
                            sdin_d = 1'b0;
                        end
                    end
                end
                RIGHT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d    = LEFT;
                        cnt_d      = '0;
                        lrck_d     = 1'b0;
                        sdin_d     = 1'b0;
                        frame_load = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc <= DATA_LAST) begin
                            sdin_d    = shift_r_q[SAMPLE_BIT_WIDTH-1];
                            shift_r_d = {shift_r_q[SAMPLE_BIT_WIDTH-2:0], 1'b0};
                        end else begin
                            sdin_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Held pair wins; otherwise a pair offered in this very cycle is used
        // directly without passing through the holding register.
        if (frame_load) begin
            if (hold_full_q) begin
                shift_l_d   = hold_l_q;
                shift_r_d   = hold_r_q;
                hold_full_d = 1'b0;
            end else if (sample_valid) begin
                shift_l_d   = sample_l;
                shift_r_d   = sample_r;
                hold_full_d = 1'b0;
            end else begin
                shift_l_d  = '0;
                shift_r_d  = '0;
                underrun_d = 1'b1;
            end
        end
    end

    // State and datapath registers; reset aborts any frame and drops held data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lrck_q      <= 1'b0;
            sdin_q      <= 1'b0;
            underrun_q  <= 1'b0;
            shift_l_q   <= '0;
            shift_r_q   <= '0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lrck_q      <= lrck_d;
            sdin_q      <= sdin_d;
            underrun_q  <= underrun_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
        end
    end

    assign sample_ready = !hold_full_q;
    assign audio_lrck   = lrck_q;
    assign audio_sdin   = sdin_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_serializer.sv
// Directed testbench for audio_serializer: frame contents, underrun, bypass,
// back-to-back producer, stalled bit clock and mid-frame reset.
module tb_audio_serializer;

    logic        clk;
    logic        reset_n;
    logic        clk_audio_bit;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;
    logic        audio_bclk;
    logic        audio_lrck;
    logic        audio_sdin;
    logic        underrun;

    int checks     = 0;
    int errors     = 0;
    int acc_count  = 0;
    int ur_cycles  = 0;
    int prod_idx   = 0;
    bit prod_en    = 1'b0;
    int acc_base;
    int ur_base;

    audio_serializer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clk_audio_bit (clk_audio_bit),
        .sample_l      (sample_l),
        .sample_r      (sample_r),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .audio_bclk    (audio_bclk),
        .audio_lrck    (audio_lrck),
        .audio_sdin    (audio_sdin),
        .underrun      (underrun)
    );

    // System clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] prodL(input int i);
        return 16'h3C5A + 16'(i) * 16'h1111;
    endfunction

    function automatic logic [15:0] prodR(input int i);
        return 16'h8421 ^ (16'(i) << 2);
    endfunction

    // I2S bit expected at slot index k: one-bit delay, MSB first, zero padding.
    function automatic logic expBit(input logic [15:0] s, input int k);
        if (k >= 1 && k <= 16) return s[16-k];
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkCount(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One system clock: note handshake/underrun mid-cycle, advance producer after the edge.
    task automatic cycle();
        logic took;
        @(negedge clk);
        took = sample_valid && sample_ready;
        if (underrun) ur_cycles++;
        @(posedge clk);
        #1;
        if (took) begin
            acc_count++;
            if (prod_en) begin
                prod_idx++;
                sample_l = prodL(prod_idx);
                sample_r = prodR(prod_idx);
            end
        end
    endtask

    // One bit-clock period ending just after the DUT has reacted to the fall.
    // With bypass set, a pair is offered exactly in the cycle the fall is seen.
    task automatic applyStimulus(input bit bypass, input logic [15:0] bl, input logic [15:0] br);
        cycle();
        clk_audio_bit = 1'b1;
        repeat (4) cycle();
        clk_audio_bit = 1'b0;
        cycle();
        cycle();
        if (bypass) begin
            sample_valid = 1'b1;
            sample_l     = bl;
            sample_r     = br;
        end
        cycle();
        if (bypass) sample_valid = 1'b0;
    endtask

    // One complete frame of 64 falls checked against the expected pair.
    task automatic checkFrame(input string tag, input logic [15:0] l, input logic [15:0] r,
                              input logic exp_ur, input bit bypass, input int stop_at);
        int k;
        int ur0;
        logic eb;
        logic el;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(bypass && (i == 0), l, r);
            k  = i % 32;
            eb = expBit((i < 32) ? l : r, k);
            el = (i >= 32);
            checkOutput($sformatf("%s_sdin_%0d", tag, i), audio_sdin, eb);
            checkOutput($sformatf("%s_lrck_%0d", tag, i), audio_lrck, el);
            checkOutput($sformatf("%s_bclk_%0d", tag, i), audio_bclk, 1'b0);
            if (i == 0) begin
                checkOutput($sformatf("%s_underrun", tag), underrun, exp_ur);
                checkOutput($sformatf("%s_ready_after_load", tag), sample_ready, 1'b1);
            end
            if (i == stop_at) begin
                ur0 = ur_cycles;
                repeat (100) cycle();
                checkOutput($sformatf("%s_stall_sdin", tag), audio_sdin, eb);
                checkOutput($sformatf("%s_stall_lrck", tag), audio_lrck, el);
                checkOutput($sformatf("%s_stall_underrun", tag), underrun, 1'b0);
                checkCount($sformatf("%s_stall_ur_cycles", tag), ur_cycles - ur0, 0);
            end
        end
    endtask

    // Directed sequence.
    initial begin
        reset_n       = 1'b0;
        clk_audio_bit = 1'b0;
        sample_valid  = 1'b0;
        sample_l      = '0;
        sample_r      = '0;
        repeat (3) cycle();

        $display("[TB] reset state");
        checkOutput("rst_bclk", audio_bclk, 1'b0);
        checkOutput("rst_lrck", audio_lrck, 1'b0);
        checkOutput("rst_sdin", audio_sdin, 1'b0);
        checkOutput("rst_underrun", underrun, 1'b0);
        checkOutput("rst_ready", sample_ready, 1'b1);
        reset_n = 1'b1;
        cycle();

        $display("[TB] preloaded first frame");
        sample_valid = 1'b1;
        sample_l     = 16'hA5C3;
        sample_r     = 16'h8001;
        cycle();
        sample_valid = 1'b0;
        checkOutput("preload_ready", sample_ready, 1'b0);
        checkFrame("f1", 16'hA5C3, 16'h8001, 1'b0, 1'b0, -1);

        $display("[TB] underrun frame");
        checkFrame("f2", 16'h0000, 16'h0000, 1'b1, 1'b0, -1);
        checkCount("ur_cycles_f2", ur_cycles, 1);

        $display("[TB] bypass at frame load");
        acc_base = acc_count;
        checkFrame("f3", 16'h7FFF, 16'h0001, 1'b0, 1'b1, -1);
        checkCount("bypass_accepts", acc_count - acc_base, 1);
        checkCount("ur_cycles_f3", ur_cycles, 1);

        $display("[TB] back-to-back producer");
        acc_base     = acc_count;
        prod_idx     = 0;
        sample_l     = prodL(0);
        sample_r     = prodR(0);
        sample_valid = 1'b1;
        prod_en      = 1'b1;
        cycle();
        checkOutput("b2b_ready_drop", sample_ready, 1'b0);
        checkCount("b2b_accepts_0", acc_count - acc_base, 1);
        for (int f = 0; f < 4; f++) begin
            checkFrame($sformatf("p%0d", f), prodL(f), prodR(f), 1'b0, 1'b0, -1);
            checkCount($sformatf("b2b_accepts_%0d", f + 1), acc_count - acc_base, f + 2);
        end
        sample_valid = 1'b0;
        prod_en      = 1'b0;

        $display("[TB] stalled bit clock");
        checkFrame("p4", prodL(4), prodR(4), 1'b0, 1'b0, 10);
        checkCount("b2b_accepts_final", acc_count - acc_base, 5);
        checkCount("ur_cycles_p4", ur_cycles, 1);

        $display("[TB] mid-frame reset");
        sample_valid = 1'b1;
        sample_l     = 16'hFFFF;
        sample_r     = 16'hFFFF;
        cycle();
        sample_valid = 1'b0;
        checkOutput("q1_ready", sample_ready, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 16'h0000, 16'h0000);
            if (i == 0) begin
                checkOutput("q1_underrun", underrun, 1'b0);
                sample_valid = 1'b1;
                sample_l     = 16'h1234;
                sample_r     = 16'h5678;
            end
            if (i == 1) sample_valid = 1'b0;
        end
        checkOutput("pre_rst_sdin", audio_sdin, 1'b1);
        checkOutput("pre_rst_ready", sample_ready, 1'b0);
        reset_n = 1'b0;
        cycle();
        checkOutput("mid_rst_lrck", audio_lrck, 1'b0);
        checkOutput("mid_rst_sdin", audio_sdin, 1'b0);
        checkOutput("mid_rst_ready", sample_ready, 1'b1);
        checkOutput("mid_rst_underrun", underrun, 1'b0);
        reset_n = 1'b1;
        ur_base = ur_cycles;
        checkFrame("post_rst", 16'h0000, 16'h0000, 1'b1, 1'b0, -1);
        checkCount("post_rst_ur_cycles", ur_cycles - ur_base, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
